// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//   Issue-side controller for the combinational 8-bit ALU. It takes one request
//   at a time over a valid/ready handshake and drives the ALU one pass at a
//   time. Each pass gets a fresh tag, and the controller waits for the ALU to
//   echo that tag back. It then captures result, carry-out and branch flag and
//   presents a response over a second valid/ready handshake. Wide (16-bit)
//   requests on the legal op subset run as two chained 8-bit passes. The second
//   pass consumes the carry produced by the first.
//   The architectural carry flag lives here.
//
// Ports
//   clk, reset          clock (rising edge) / asynchronous active-low reset
//   req_valid/ready     request handshake; ready only while idle
//   req_op, req_wide    ALU op code and 16-bit two-pass request
//   req_cin_clr         clear the carry flag before the first pass
//   req_a, req_b        16-bit operands (upper byte used only when wide)
//   alu_op/a/b/cin/tag  registered drive to the ALU (held while idle)
//   alu_rslt/cout/branch/echo   ALU outputs; echo == tag marks a valid result
//   rsp_valid/ready     response handshake
//   rsp_rslt            {hi, lo}; hi is zero for narrow ops, all zero on error
//   rsp_carry           carry flag after the op
//   rsp_branch          branch flag from the low pass
//   rsp_err             ALU failed to echo within TIMEOUT cycles
//   carry_flag          architectural carry
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int CTR_W   = 12,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic             req_wide,
  input  logic             req_cin_clr,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  output logic [4:0]       alu_op,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic             alu_cin,
  output logic [CTR_W-1:0] alu_tag,
  input  logic [7:0]       alu_rslt,
  input  logic             alu_cout,
  input  logic             alu_branch,
  input  logic [CTR_W-1:0] alu_echo,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_rslt,
  output logic             rsp_carry,
  output logic             rsp_branch,
  output logic             rsp_err,
  output logic             carry_flag
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_LO,
    WAIT_LO,
    ISSUE_HI,
    WAIT_HI,
    RESP
  } state_t;

  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  // Ops that may be split into two chained 8-bit passes.
  function automatic logic is_wide_op(input logic [4:0] op);
    return op inside {5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01010, 5'b01101};
  endfunction

  // Ops whose carry-out becomes the architectural carry.
  function automatic logic is_carry_op(input logic [4:0] op);
    return op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01010, 5'b01101};
  endfunction

  state_t          state;
  logic [4:0]      op_q;
  logic [15:0]     a_q;
  logic [15:0]     b_q;
  logic [7:0]      lo_q;
  logic [7:0]      hi_q;
  logic            wide_q;
  logic            branch_q;
  logic            err_q;
  logic            carry_save;
  logic [TO_W-1:0] wait_cnt;

  logic accept;
  logic echo_hit;
  logic timed_out;

  assign accept    = (state == IDLE) && req_valid && req_ready;
  // The ALU is combinational, so a matching echo means alu_rslt belongs to
  // the pass currently on the alu_* outputs.
  assign echo_hit  = (alu_echo == alu_tag);
  assign timed_out = (wait_cnt == TO_W'(TIMEOUT - 1));

  // Operand and result capture; pure datapath, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= req_op;
      a_q  <= req_a;
      b_q  <= req_b;
      hi_q <= 8'h00;
    end
    if (state == WAIT_LO && echo_hit) lo_q <= alu_rslt;
    if (state == WAIT_HI && echo_hit) hi_q <= alu_rslt;
  end

  // Control FSM with all externally visible outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cin    <= 1'b0;
      alu_tag    <= '0;
      rsp_valid  <= 1'b0;
      rsp_rslt   <= '0;
      rsp_carry  <= 1'b0;
      rsp_branch <= 1'b0;
      rsp_err    <= 1'b0;
      carry_flag <= 1'b0;
      wide_q     <= 1'b0;
      branch_q   <= 1'b0;
      err_q      <= 1'b0;
      carry_save <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (accept) begin
            req_ready  <= 1'b0;
            wide_q     <= req_wide && is_wide_op(req_op);
            // Pre-op carry is what a timed-out op must restore.
            carry_save <= carry_flag;
            branch_q   <= 1'b0;
            err_q      <= 1'b0;
            if (req_cin_clr) carry_flag <= 1'b0;
            state      <= ISSUE_LO;
          end else begin
            req_ready <= 1'b1;
          end
        end

        ISSUE_LO: begin
          alu_op   <= op_q;
          alu_a    <= a_q[7:0];
          alu_b    <= b_q[7:0];
          alu_cin  <= carry_flag;
          alu_tag  <= alu_tag + CTR_W'(1);
          wait_cnt <= '0;
          state    <= WAIT_LO;
        end

        WAIT_LO: begin
          if (echo_hit) begin
            branch_q <= alu_branch;
            if (is_carry_op(op_q)) carry_flag <= alu_cout;
            state <= wide_q ? ISSUE_HI : RESP;
          end else if (timed_out) begin
            err_q      <= 1'b1;
            branch_q   <= 1'b0;
            carry_flag <= carry_save;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end

        ISSUE_HI: begin
          // carry_flag already holds the low-pass carry-out here.
          alu_a    <= a_q[15:8];
          alu_b    <= b_q[15:8];
          alu_cin  <= carry_flag;
          alu_tag  <= alu_tag + CTR_W'(1);
          wait_cnt <= '0;
          state    <= WAIT_HI;
        end

        WAIT_HI: begin
          if (echo_hit) begin
            if (is_carry_op(op_q)) carry_flag <= alu_cout;
            state <= RESP;
          end else if (timed_out) begin
            err_q      <= 1'b1;
            branch_q   <= 1'b0;
            carry_flag <= carry_save;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end

        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            // Sources are frozen while in RESP, so these reloads keep rsp_* stable.
            rsp_valid  <= 1'b1;
            rsp_rslt   <= err_q ? 16'h0000 : {hi_q, lo_q};
            rsp_carry  <= carry_flag;
            rsp_branch <= branch_q;
            rsp_err    <= err_q;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  localparam int CTR_W   = 12;
  localparam int TIMEOUT = 15;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_op;
  logic             req_wide;
  logic             req_cin_clr;
  logic [15:0]      req_a;
  logic [15:0]      req_b;
  logic [4:0]       alu_op;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic             alu_cin;
  logic [CTR_W-1:0] alu_tag;
  logic [7:0]       alu_rslt;
  logic             alu_cout;
  logic             alu_branch;
  logic [CTR_W-1:0] alu_echo;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [15:0]      rsp_rslt;
  logic             rsp_carry;
  logic             rsp_branch;
  logic             rsp_err;
  logic             carry_flag;

  logic             echo_en;
  int               total;
  int               bad;

  // Pass details recorded while an op runs.
  logic [CTR_W-1:0] lo_tag, hi_tag;
  logic             lo_cin, hi_cin;
  int               lat, acc_wait;

  alu_issue_ctrl #(.CTR_W(CTR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_wide   (req_wide),
    .req_cin_clr(req_cin_clr),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_tag    (alu_tag),
    .alu_rslt   (alu_rslt),
    .alu_cout   (alu_cout),
    .alu_branch (alu_branch),
    .alu_echo   (alu_echo),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rslt   (rsp_rslt),
    .rsp_carry  (rsp_carry),
    .rsp_branch (rsp_branch),
    .rsp_err    (rsp_err),
    .carry_flag (carry_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small combinational ALU: 00000 AND, 00001 OR, 00011 add with carry-in,
  // 01000 EQ (branch only). Echo is withheld when echo_en is low.
  always_comb begin
    logic [8:0] sum;
    sum        = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
    alu_rslt   = 8'h00;
    alu_cout   = 1'b0;
    alu_branch = 1'b0;
    case (alu_op)
      5'b00000: alu_rslt = alu_a & alu_b;
      5'b00001: alu_rslt = alu_a | alu_b;
      5'b00011: begin
        alu_rslt = sum[7:0];
        alu_cout = sum[8];
      end
      5'b01000: alu_branch = (alu_a == alu_b);
      default: ;
    endcase
  end
  assign alu_echo = echo_en ? alu_tag : ~alu_tag;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present a request, wait for acceptance, then count cycles to rsp_valid.
  task automatic run_op(input logic [4:0] op, input logic wide, input logic clr,
                        input logic [15:0] a, input logic [15:0] b);
    req_op = op; req_wide = wide; req_cin_clr = clr; req_a = a; req_b = b;
    req_valid = 1'b1;
    acc_wait = 0;
    while (!req_ready && acc_wait < 50) begin
      @(posedge clk); #1;
      acc_wait++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin lo_tag = alu_tag; lo_cin = alu_cin; end
      if (lat == 3) begin hi_tag = alu_tag; hi_cin = alu_cin; end
    end
  endtask

  // Let the response handshake complete (rsp_ready assumed high).
  task automatic drain;
    int n;
    n = 0;
    while (rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    logic [15:0] hold_rslt;
    int errs;
    logic seen;
    total = 0; bad = 0;
    reset = 1'b0; req_valid = 1'b0; req_op = '0; req_wide = 1'b0;
    req_cin_clr = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b1; echo_en = 1'b1;

    // Reset state
    #12;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_alu_tag", alu_tag, 0);
    chk("rst_carry", carry_flag, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    #10 reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_req_ready", req_ready, 1);

    // 1: AND narrow
    run_op(5'b00000, 1'b0, 1'b0, 16'h000F, 16'h003C);
    chk("t1_tag", lo_tag, 1);
    chk("t1_lat", lat, 3);
    chk("t1_rslt", rsp_rslt, 16'h000C);
    chk("t1_carry", rsp_carry, 0);
    drain();

    // 2: wide add with carry chain
    run_op(5'b00011, 1'b1, 1'b1, 16'h01FF, 16'h0001);
    chk("t2_tag_lo", lo_tag, 2);
    chk("t2_tag_hi", hi_tag, 3);
    chk("t2_cin_lo", lo_cin, 0);
    chk("t2_cin_hi", hi_cin, 1);
    chk("t2_lat", lat, 5);
    chk("t2_rslt", rsp_rslt, 16'h0200);
    chk("t2_carry", rsp_carry, 0);
    drain();

    // Set carry to 1 for the carry-preservation checks below
    run_op(5'b00011, 1'b0, 1'b1, 16'h0080, 16'h0080);
    chk("setc_rslt", rsp_rslt, 16'h0000);
    chk("setc_carry", rsp_carry, 1);
    drain();

    // 3: EQ with wide requested but not legal -> single pass
    run_op(5'b01000, 1'b1, 1'b0, 16'h1255, 16'h3455);
    chk("t3_lat", lat, 3);
    chk("t3_branch", rsp_branch, 1);
    chk("t3_rslt", rsp_rslt, 16'h0000);
    chk("t3_carry", carry_flag, 1);
    drain();

    // 4: response backpressure
    rsp_ready = 1'b0;
    run_op(5'b00001, 1'b0, 1'b0, 16'h00F0, 16'h000F);
    chk("t4_lat", lat, 3);
    hold_rslt = rsp_rslt;
    chk("t4_rslt", hold_rslt, 16'h00FF);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_valid", rsp_valid, 1);
      chk("t4_hold_rslt", rsp_rslt, 16'h00FF);
      chk("t4_busy_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_rsp_drop", rsp_valid, 0);
    chk("t4_ready_back", req_ready, 1);
    run_op(5'b00000, 1'b0, 1'b0, 16'h00AA, 16'h000F);
    chk("t4_acc_wait", acc_wait, 0);
    chk("t4_next_rslt", rsp_rslt, 16'h000A);
    chk("t4_carry", rsp_carry, 1);
    drain();

    // 5: ALU never echoes -> timeout
    echo_en = 1'b0;
    run_op(5'b00011, 1'b0, 1'b0, 16'h00FF, 16'h0001);
    chk("t5_lat", lat, TIMEOUT + 2);
    chk("t5_err", rsp_err, 1);
    chk("t5_rslt", rsp_rslt, 16'h0000);
    chk("t5_carry", carry_flag, 1);
    drain();
    echo_en = 1'b1;
    run_op(5'b00000, 1'b0, 1'b0, 16'h0033, 16'h00FF);
    chk("t5_err_clr", rsp_err, 0);
    chk("t5_after_rslt", rsp_rslt, 16'h0033);
    drain();

    // 6: reset during WAIT_HI
    req_op = 5'b00011; req_wide = 1'b1; req_cin_clr = 1'b0;
    req_a = 16'h01FF; req_b = 16'h0101; req_valid = 1'b1;
    @(posedge clk); #1;          // accepted
    req_valid = 1'b0;
    @(posedge clk); #1;          // low pass on the ALU
    @(posedge clk); #1;          // low capture, carry = 1
    chk("t6_mid_carry", carry_flag, 1);
    @(posedge clk); #1;          // now in WAIT_HI
    reset = 1'b0;
    #1;
    chk("t6_rst_tag", alu_tag, 0);
    chk("t6_rst_a", alu_a, 0);
    chk("t6_rst_carry", carry_flag, 0);
    chk("t6_rst_ready", req_ready, 0);
    #8 reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk("t6_no_rsp", seen, 0);
    run_op(5'b00000, 1'b0, 1'b0, 16'h00F0, 16'h0030);
    chk("t6_tag1", lo_tag, 1);
    chk("t6_rslt", rsp_rslt, 16'h0030);
    drain();

    // Tag wrap: issues 2..4095 unchecked individually, issue 4096 carries tag 0
    errs = 0;
    for (int i = 2; i <= 4095; i++) begin
      run_op(5'b00000, 1'b0, 1'b0, 16'(i), 16'h00F0);
      if (rsp_rslt !== {8'h00, 8'(i) & 8'hF0} || lat != 3) errs++;
      drain();
    end
    chk("wrap_run_errs", errs, 0);
    chk("wrap_pre_tag", lo_tag, 12'hFFF);
    run_op(5'b00001, 1'b0, 1'b0, 16'h0012, 16'h0040);
    chk("wrap_tag0", lo_tag, 0);
    chk("wrap_rslt", rsp_rslt, 16'h0052);
    chk("wrap_lat", lat, 3);
    drain();
    run_op(5'b00000, 1'b0, 1'b0, 16'h00FF, 16'h0081);
    chk("wrap_tag1", lo_tag, 1);
    chk("wrap_rslt2", rsp_rslt, 16'h0081);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
